// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode type, width limit and the edge-role selector
package spi_pkg;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
  localparam int SPI_MAX_WIDTH = 32;
  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge; the other edge shifts
  function automatic logic sample_edge(spi_mode_t m, logic lead, logic trail);
    return m.cpha ? trail : lead;
  endfunction
  function automatic logic shift_edge(spi_mode_t m, logic lead, logic trail);
    return m.cpha ? lead : trail;
  endfunction
endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: synchronous FIFO (push/pop/peek); push ignored when full, pop ignored when empty
module spi_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      level <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/spi_peripheral_os.sv
// spi_peripheral_os: oversampled SPI peripheral (modes 0-3), multi-word frames, TX FIFO
module spi_peripheral_os
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_cpol,
  input  logic                          i_cpha,
  input  logic                          i_txValid,
  output logic                          o_txReady,
  input  logic [WIDTH-1:0]              i_txData,
  output logic [$clog2(TX_DEPTH+1)-1:0] o_txLevel,
  output logic                          o_rxValid,
  output logic [WIDTH-1:0]              o_rxData,
  output logic                          o_txUnderrun,
  output logic                          o_rxAbort,
  output logic                          o_busy,
  input  logic                          i_SPI_CLK,
  input  logic                          i_SPI_PICO,
  input  logic                          i_SPI_CS_n,
  output logic                          o_SPI_POCI,
  output logic                          o_SPI_POCI_en
);
  localparam int CW = $clog2(WIDTH);
  if (WIDTH < 4 || WIDTH > SPI_MAX_WIDTH || SYNC_STAGES < 2 || TX_DEPTH < 2) begin : g_bad_param
    $error("spi_peripheral_os: unsupported parameter set");
  end
  logic [SYNC_STAGES-1:0] sclk_sync, pico_sync, cs_sync;
  logic sclk_s, pico_s, cs_s, sclk_d, cs_d;
  logic active, lead, trail, sample, shift, commit, cs_fall, cs_rise;
  logic full, empty;
  logic [WIDTH-1:0] head, head_or_zero, tx_shift;
  logic [WIDTH-2:0] rx_shift;
  logic [CW-1:0] bit_cnt;
  spi_mode_t mode;
  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign pico_s  = pico_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
  // SCLK edges only count once CS_n has been low for a full cycle
  assign active  = ~cs_d & ~cs_s;
  assign lead    = active & (sclk_d == mode.cpol) & (sclk_s != mode.cpol);
  assign trail   = active & (sclk_d != mode.cpol) & (sclk_s == mode.cpol);
  assign sample  = sample_edge(mode, lead, trail);
  assign shift   = shift_edge(mode, lead, trail);
  // the word is consumed on its first sample edge, so a trailing spare shift edge never pops
  assign commit  = sample & (bit_cnt == '0);
  assign head_or_zero = empty ? '0 : head;
  assign o_txReady     = ~full;
  assign o_SPI_POCI    = tx_shift[WIDTH-1];
  assign o_SPI_POCI_en = o_busy;
  spi_tx_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (i_txValid),
    .pop   (commit),
    .din   (i_txData),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (o_txLevel)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sclk_sync <= '0;
      pico_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_CLK};
      pico_sync <= {pico_sync[SYNC_STAGES-2:0], i_SPI_PICO};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      mode         <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      o_rxData     <= '0;
      o_rxValid    <= 1'b0;
      o_txUnderrun <= 1'b0;
      o_rxAbort    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_rxValid    <= 1'b0;
      o_txUnderrun <= 1'b0;
      o_rxAbort    <= 1'b0;
      o_busy       <= ~cs_s;
      if (cs_fall) begin
        mode    <= '{cpol: i_cpol, cpha: i_cpha};
        bit_cnt <= '0;
        if (!i_cpha) tx_shift <= head_or_zero;
      end else if (cs_rise) begin
        if (bit_cnt != '0) o_rxAbort <= 1'b1;
        bit_cnt <= '0;
      end else begin
        if (shift) tx_shift <= (bit_cnt == '0) ? head_or_zero : {tx_shift[WIDTH-2:0], 1'b0};
        if (sample) begin
          rx_shift <= {rx_shift[WIDTH-3:0], pico_s};
          bit_cnt  <= (bit_cnt == CW'(WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
          if (commit && empty) o_txUnderrun <= 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            o_rxData  <= {rx_shift, pico_s};
            o_rxValid <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_spi_peripheral_os.sv
// tb_spi_peripheral_os: randomized frames in all modes checked against a queue-based model
module tb_spi_peripheral_os;
  localparam int HALF = 100;
  logic       i_clk = 1'b0, i_rst_n = 1'b0, i_cpol = 1'b0, i_cpha = 1'b0, i_txValid = 1'b0;
  logic [7:0] i_txData = '0;
  logic       i_SPI_CLK = 1'b0, i_SPI_PICO = 1'b0, i_SPI_CS_n = 1'b1;
  logic       o_txReady, o_rxValid, o_txUnderrun, o_rxAbort, o_busy, o_SPI_POCI, o_SPI_POCI_en;
  logic [2:0] o_txLevel;
  logic [7:0] o_rxData;
  int total = 0, bad = 0, n_under = 0, n_abort = 0, exp_under = 0;
  logic [7:0] rx_log[$];
  logic [7:0] model_q[$];

  spi_peripheral_os #(.WIDTH(8), .TX_DEPTH(4), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cpol(i_cpol), .i_cpha(i_cpha),
    .i_txValid(i_txValid), .o_txReady(o_txReady), .i_txData(i_txData), .o_txLevel(o_txLevel),
    .o_rxValid(o_rxValid), .o_rxData(o_rxData), .o_txUnderrun(o_txUnderrun), .o_rxAbort(o_rxAbort),
    .o_busy(o_busy), .i_SPI_CLK(i_SPI_CLK), .i_SPI_PICO(i_SPI_PICO), .i_SPI_CS_n(i_SPI_CS_n),
    .o_SPI_POCI(o_SPI_POCI), .o_SPI_POCI_en(o_SPI_POCI_en)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk)
    if (i_rst_n) begin
      if (o_rxValid) rx_log.push_back(o_rxData);
      if (o_txUnderrun) n_under++;
      if (o_rxAbort) n_abort++;
    end

  // model: each started word takes the FIFO head, or zeros plus one underrun when empty
  task automatic model_commit(output logic [7:0] w);
    if (model_q.size() != 0) w = model_q.pop_front();
    else begin
      w = '0;
      exp_under++;
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    @(negedge i_clk);
    i_txValid = 1'b1;
    i_txData  = w;
    total++;
    if (o_txReady !== (model_q.size() < 4)) begin
      bad++;
      $display("FAIL push_ready got %b want %b", o_txReady, model_q.size() < 4);
    end
    @(posedge i_clk);
    #1 i_txValid = 1'b0;
    if (model_q.size() < 4) model_q.push_back(w);
  endtask

  // controller side: drives SCLK/PICO and captures POCI on the mode's sample edge
  task automatic frame(input logic cpol, input logic cpha, input int nbits, input logic [63:0] mosi,
                       input bit hold_cs, output logic [63:0] miso);
    miso = '0;
    @(negedge i_clk);
    i_cpol = cpol;
    i_cpha = cpha;
    i_SPI_CLK = cpol;
    #(HALF);
    i_SPI_CS_n = 1'b0;
    if (!cpha) i_SPI_PICO = mosi[63];
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        miso[63-i] = o_SPI_POCI;
        i_SPI_CLK = ~cpol;
        #(HALF);
        i_SPI_CLK = cpol;
        if (i + 1 < nbits) i_SPI_PICO = mosi[62-i];
        #(HALF);
      end else begin
        i_SPI_CLK = ~cpol;
        i_SPI_PICO = mosi[63-i];
        #(HALF);
        miso[63-i] = o_SPI_POCI;
        i_SPI_CLK = cpol;
        #(HALF);
      end
    end
    if (!hold_cs) begin
      i_SPI_CS_n = 1'b1;
      #(HALF);
    end
  endtask

  task automatic test_frame_words(input string tag, input logic cpol, input logic cpha, input int nw,
                                  input logic [63:0] mosi);
    logic [63:0] miso, expv;
    logic [7:0] w;
    int r0, u0, eu0;
    r0 = rx_log.size();
    u0 = n_under;
    eu0 = exp_under;
    expv = '0;
    for (int k = 0; k < nw; k++) begin
      model_commit(w);
      expv = (expv << 8) | 64'(w);
    end
    frame(cpol, cpha, 8 * nw, mosi, 1'b0, miso);
    total++;
    if ((miso >> (64 - 8 * nw)) !== expv) begin
      bad++;
      $display("FAIL %s_poci got %h want %h", tag, miso >> (64 - 8 * nw), expv);
    end
    total++;
    if (rx_log.size() - r0 != nw) begin
      bad++;
      $display("FAIL %s_rx_count got %0d want %0d", tag, rx_log.size() - r0, nw);
    end else
      for (int k = 0; k < nw; k++) begin
        total++;
        if (rx_log[r0+k] !== mosi[63-8*k -: 8]) begin
          bad++;
          $display("FAIL %s_rx_data%0d got %h want %h", tag, k, rx_log[r0+k], mosi[63-8*k -: 8]);
        end
      end
    total++;
    if (n_under - u0 != exp_under - eu0) begin
      bad++;
      $display("FAIL %s_underrun got %0d want %0d", tag, n_under - u0, exp_under - eu0);
    end
    total++;
    if (o_txLevel !== 3'(model_q.size())) begin
      bad++;
      $display("FAIL %s_level got %0d want %0d", tag, o_txLevel, model_q.size());
    end
  endtask

  task automatic test_reset;
    repeat (5) @(negedge i_clk);
    total++;
    if ({o_rxValid, o_rxData, o_txReady, o_txLevel, o_txUnderrun, o_rxAbort, o_busy, o_SPI_POCI, o_SPI_POCI_en}
        !== {1'b0, 8'h00, 1'b1, 3'd0, 5'b0}) begin
      bad++;
      $display("FAIL reset_in got %b want rdy=1 others 0",
               {o_rxValid, o_rxData, o_txReady, o_txLevel, o_txUnderrun, o_rxAbort, o_busy, o_SPI_POCI, o_SPI_POCI_en});
    end
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    total++;
    if ({o_txReady, o_txLevel, o_busy, o_SPI_POCI_en} !== 6'b1_000_0_0) begin
      bad++;
      $display("FAIL reset_out got %b want 100000", {o_txReady, o_txLevel, o_busy, o_SPI_POCI_en});
    end
  endtask

  task automatic test_mode0;
    push_word(8'h3C);
    test_frame_words("mode0", 1'b0, 1'b0, 1, {8'hA5, 56'h0});
  endtask

  task automatic test_mode3_two_words;
    push_word(8'h11);
    push_word(8'h22);
    test_frame_words("mode3", 1'b1, 1'b1, 2, {16'hF00F, 48'h0});
  endtask

  task automatic test_mode1_underrun;
    test_frame_words("mode1_empty", 1'b0, 1'b1, 1, {8'($urandom), 56'h0});
  endtask

  task automatic test_abort;
    logic [63:0] miso, mosi;
    logic [7:0] w;
    logic [7:0] held;
    int r0, a0;
    push_word(8'($urandom));
    push_word(8'($urandom));
    mosi = {$urandom, $urandom};
    r0 = rx_log.size();
    a0 = n_abort;
    held = o_rxData;
    model_commit(w);
    frame(1'b0, 1'b0, 5, mosi, 1'b0, miso);
    total++;
    if (miso[63:59] !== w[7:3]) begin
      bad++;
      $display("FAIL abort_poci got %b want %b", miso[63:59], w[7:3]);
    end
    total++;
    if (n_abort - a0 != 1) begin
      bad++;
      $display("FAIL abort_pulse got %0d want 1", n_abort - a0);
    end
    total++;
    if (rx_log.size() != r0 || o_rxData !== held) begin
      bad++;
      $display("FAIL abort_rx got n=%0d data=%h want n=%0d data=%h", rx_log.size(), o_rxData, r0, held);
    end
    total++;
    if (o_txLevel !== 3'(model_q.size())) begin
      bad++;
      $display("FAIL abort_level got %0d want %0d", o_txLevel, model_q.size());
    end
    test_frame_words("after_abort", 1'b0, 1'b0, 1, {$urandom, $urandom});
  endtask

  task automatic test_fifo_full;
    logic [63:0] miso, mosi;
    logic [7:0] w, w5;
    int c;
    for (int k = 0; k < 4; k++) push_word(8'($urandom));
    w5 = 8'($urandom);
    @(negedge i_clk);
    i_txValid = 1'b1;
    i_txData  = w5;
    total++;
    if (o_txReady !== 1'b0 || o_txLevel !== 3'd4) begin
      bad++;
      $display("FAIL full_refuse got rdy=%b lvl=%0d want rdy=0 lvl=4", o_txReady, o_txLevel);
    end
    mosi = {$urandom, $urandom};
    model_commit(w);
    fork
      frame(1'b0, 1'b0, 8, mosi, 1'b0, miso);
      begin
        c = 0;
        @(negedge i_clk);
        while (o_txReady !== 1'b1 && c < 3000) begin
          @(negedge i_clk);
          c++;
        end
        total++;
        if (c >= 3000 || o_txLevel !== 3'd3) begin
          bad++;
          $display("FAIL full_pop got lvl=%0d cycles=%0d want lvl=3 within 3000", o_txLevel, c);
        end
        @(posedge i_clk);
        #1 i_txValid = 1'b0;
        @(negedge i_clk);
        total++;
        if (o_txLevel !== 3'd4) begin
          bad++;
          $display("FAIL full_late_push got lvl=%0d want 4", o_txLevel);
        end
      end
    join
    model_q.push_back(w5);
    total++;
    if (miso[63:56] !== w) begin
      bad++;
      $display("FAIL full_first_word got %h want %h", miso[63:56], w);
    end
    test_frame_words("drain", 1'($urandom), 1'($urandom), 4, {$urandom, $urandom});
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] miso;
    push_word(8'($urandom));
    frame(1'b1, 1'b0, 4, {$urandom, $urandom}, 1'b1, miso);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    total++;
    if ({o_rxValid, o_rxData, o_txReady, o_txLevel, o_txUnderrun, o_rxAbort, o_busy, o_SPI_POCI, o_SPI_POCI_en}
        !== {1'b0, 8'h00, 1'b1, 3'd0, 5'b0}) begin
      bad++;
      $display("FAIL midframe_reset got %b want rdy=1 others 0",
               {o_rxValid, o_rxData, o_txReady, o_txLevel, o_txUnderrun, o_rxAbort, o_busy, o_SPI_POCI, o_SPI_POCI_en});
    end
    model_q.delete();
    #50 i_SPI_CS_n = 1'b1;
    repeat (10) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    push_word(8'($urandom));
    test_frame_words("after_reset", 1'b1, 1'b0, 1, {$urandom, $urandom});
  endtask

  task automatic test_random;
    int np, nw;
    for (int r = 0; r < 6; r++) begin
      np = $urandom_range(0, 3);
      nw = $urandom_range(1, 3);
      for (int k = 0; k < np; k++) push_word(8'($urandom));
      test_frame_words($sformatf("rand%0d", r), 1'($urandom), 1'($urandom), nw, {$urandom, $urandom});
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode3_two_words;
    test_mode1_underrun;
    test_abort;
    test_fifo_full;
    test_reset_mid_frame;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
